// File: rtl/sc_io_pkg.sv
// Shared constants for the memory-mapped switch / seven-segment / timer responder.
package sc_io_pkg;

    localparam logic [3:0] OFS_SW       = 4'd0;
    localparam logic [3:0] OFS_SW_EDGE  = 4'd1;
    localparam logic [3:0] OFS_HEX_DATA = 4'd4;
    localparam logic [3:0] OFS_HEX_CTRL = 4'd5;
    localparam logic [3:0] OFS_TIMER    = 4'd8;

    localparam logic [31:0] DEFAULT_BASE_ADDR       = 32'hFFFF_FF00;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

    // Display enabled, no digit blanked: every digit shows "0" out of reset.
    localparam logic [6:0] HEX_CTRL_RESET = 7'b000_0001;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_seg7 (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (digit_i)
            4'h0:    seg_o = 7'b1000000;
            4'h1:    seg_o = 7'b1111001;
            4'h2:    seg_o = 7'b0100100;
            4'h3:    seg_o = 7'b0110000;
            4'h4:    seg_o = 7'b0011001;
            4'h5:    seg_o = 7'b0010010;
            4'h6:    seg_o = 7'b0000010;
            4'h7:    seg_o = 7'b1111000;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0010000;
            4'hA:    seg_o = 7'b0001000;
            4'hB:    seg_o = 7'b0000011;
            4'hC:    seg_o = 7'b1000110;
            4'hD:    seg_o = 7'b0100001;
            4'hE:    seg_o = 7'b0000110;
            default: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/sc_io_responder.sv
// Memory-mapped I/O responder: debounced switches with edge latch, six-digit hex display
// and a free-running timer, all in one 64-byte window.
module sc_io_responder
    import sc_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        sel,
    output logic [31:0] rdata,
    input  logic [7:0]  switch_input,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam logic [15:0] CntMax  = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] CntLoad = 16'(DEBOUNCE_CYCLES - 2);

    logic [7:0]  sync1_q, sync2_q;
    logic [7:0]  cand_q, cand_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  sw_q, sw_d;
    logic [7:0]  edge_q, edge_d;
    logic [23:0] hex_data_q, hex_data_d;
    logic [6:0]  hex_ctrl_q, hex_ctrl_d;
    logic [31:0] timer_q, timer_d;

    logic       wr;
    logic [3:0] ofs;
    logic       unused_addr;

    assign sel         = (addr[31:6] == BASE_ADDR[31:6]);
    assign ofs         = addr[5:2];
    assign wr          = we & sel;
    assign unused_addr = ^addr[1:0];

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        sw_d   = sw_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 16'd1;
            // The stable register follows on the edge the counter reaches its ceiling.
            if (cnt_q == CntLoad) begin
                sw_d = cand_q;
            end
        end

        edge_d = edge_q;
        if (wr && ofs == OFS_SW_EDGE) begin
            edge_d = edge_q & ~wdata[7:0];
        end
        edge_d = edge_d | (sw_q ^ sw_d);

        hex_data_d = (wr && ofs == OFS_HEX_DATA) ? wdata[23:0] : hex_data_q;
        hex_ctrl_d = (wr && ofs == OFS_HEX_CTRL) ? wdata[6:0]  : hex_ctrl_q;
        timer_d    = (wr && ofs == OFS_TIMER)    ? wdata       : timer_q + 32'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            sw_q       <= '0;
            edge_q     <= '0;
            hex_data_q <= '0;
            hex_ctrl_q <= HEX_CTRL_RESET;
            timer_q    <= '0;
        end else begin
            sync1_q    <= switch_input;
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            sw_q       <= sw_d;
            edge_q     <= edge_d;
            hex_data_q <= hex_data_d;
            hex_ctrl_q <= hex_ctrl_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (ofs)
                OFS_SW:       rdata = {24'd0, sw_q};
                OFS_SW_EDGE:  rdata = {24'd0, edge_q};
                OFS_HEX_DATA: rdata = {8'd0, hex_data_q};
                OFS_HEX_CTRL: rdata = {25'd0, hex_ctrl_q};
                OFS_TIMER:    rdata = timer_q;
                default:      rdata = '0;
            endcase
        end
    end

    logic [6:0] seg_raw [6];
    logic [6:0] seg     [6];

    for (genvar k = 0; k < 6; k++) begin : g_digit
        hex_to_seg7 u_seg (
            .digit_i (hex_data_q[4*k +: 4]),
            .seg_o   (seg_raw[k])
        );
        assign seg[k] = (!hex_ctrl_q[0] || hex_ctrl_q[k+1]) ? 7'h7F : seg_raw[k];
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];

endmodule

// File: tb/tb_sc_io_responder.sv
// Scoreboard bench for sc_io_responder: directed scenarios plus random bus/switch traffic
// against a cycle-level behavioural model.
module tb_sc_io_responder;

    localparam int unsigned DEB  = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [41:0] HEX_ZEROS = {6{7'b1000000}};
    localparam logic [41:0] HEX_12AB3F = {7'b1111001, 7'b0100100, 7'b0001000,
                                          7'b0000011, 7'b0110000, 7'b0001110};
    localparam logic [41:0] HEX_BLANK1 = {7'b1111001, 7'b0100100, 7'b0001000,
                                          7'b0000011, 7'b1111111, 7'b0001110};

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] addr = BASE;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        sel;
    logic [31:0] rdata;
    logic [7:0]  switch_input = '0;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    sc_io_responder #(
        .DEBOUNCE_CYCLES (DEB),
        .BASE_ADDR       (BASE)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .addr         (addr),
        .wdata        (wdata),
        .we           (we),
        .sel          (sel),
        .rdata        (rdata),
        .switch_input (switch_input),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .hex3         (hex3),
        .hex4         (hex4),
        .hex5         (hex5)
    );

    always #5 clock = ~clock;

    // Behavioural model state: what each register holds after the latest clock edge.
    logic [7:0]  m_sw, m_edge;
    logic [23:0] m_hexd;
    logic [6:0]  m_hexc;
    logic [31:0] m_timer;
    logic [7:0]  hist [$];
    logic [7:0]  run_val;
    int          run_len;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        sel;
        logic [41:0] hex;
    } exp_t;

    exp_t sb [$];
    int   total = 0;
    int   bad = 0;
    logic [7:0] cur_sw = '0;
    logic       rst_req = 1'b0;

    function automatic logic in_win(input logic [31:0] a);
        return a[31:6] == BASE[31:6];
    endfunction

    function automatic logic [31:0] oa(input logic [3:0] o);
        return BASE | {26'd0, o, 2'b00};
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_win(a)) return 32'd0;
        case (a[5:2])
            4'd0:    return {24'd0, m_sw};
            4'd1:    return {24'd0, m_edge};
            4'd4:    return {8'd0, m_hexd};
            4'd5:    return {25'd0, m_hexc};
            4'd8:    return m_timer;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [41:0] model_hex();
        logic [41:0] r;
        for (int k = 0; k < 6; k++) begin
            r[7*k +: 7] = (!m_hexc[0] || m_hexc[k+1]) ? 7'h7F : glyph[m_hexd[4*k +: 4]];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_sw = '0; m_edge = '0; m_hexd = '0; m_hexc = 7'd1; m_timer = '0;
        hist = {8'h00, 8'h00};
        run_val = '0;
        run_len = 1;
    endtask

    // A switch value is accepted once the synchronized input (two edges late) has shown it on
    // DEB consecutive edges.
    task automatic model_edge();
        logic [7:0] s2, new_sw;
        logic       hit;
        hist.push_back(switch_input);
        s2 = hist[hist.size() - 3];
        if (hist.size() > 3) void'(hist.pop_front());
        if (s2 == run_val) run_len++;
        else begin
            run_val = s2;
            run_len = 1;
        end
        new_sw = (run_len == DEB) ? run_val : m_sw;
        hit = we && in_win(addr);
        if (hit && addr[5:2] == 4'd1) m_edge = m_edge & ~wdata[7:0];
        m_edge = m_edge | (m_sw ^ new_sw);
        m_sw = new_sw;
        if (hit && addr[5:2] == 4'd4) m_hexd = wdata[23:0];
        if (hit && addr[5:2] == 4'd5) m_hexc = wdata[6:0];
        m_timer = (hit && addr[5:2] == 4'd8) ? wdata : m_timer + 32'd1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge resetn);
            if (!resetn) model_reset();
            else model_edge();
        end
    end

    task automatic check(input string nm, input string what, input logic [41:0] act,
                         input logic [41:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %h expected %h", nm, what, act, exp);
        end
    endtask

    // Monitor: every negedge, compare the outputs against all pending expectations.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, "rdata", {10'd0, rdata}, {10'd0, e.rd});
                check(e.name, "sel", {41'd0, sel}, {41'd0, e.sel});
                check(e.name, "hex", {hex5, hex4, hex3, hex2, hex1, hex0}, e.hex);
            end
        end
    end

    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input string nm, input bit use_c, input logic [31:0] c,
                        input bit use_h, input logic [41:0] h);
        exp_t e;
        @(posedge clock);
        #1;
        addr = a; we = w; wdata = d; switch_input = cur_sw; resetn = rst_req;
        #1;
        e.name = nm;
        e.rd   = use_c ? c : model_read(a);
        e.sel  = in_win(a);
        e.hex  = use_h ? h : model_hex();
        sb.push_back(e);
    endtask

    task automatic rd(input logic [3:0] o, input string nm);
        step(oa(o), 1'b0, 32'd0, nm, 1'b0, 32'd0, 1'b0, 42'd0);
    endtask

    task automatic rdc(input logic [3:0] o, input string nm, input logic [31:0] c);
        step(oa(o), 1'b0, 32'd0, nm, 1'b1, c, 1'b0, 42'd0);
    endtask

    task automatic wr(input logic [3:0] o, input logic [31:0] d, input string nm);
        step(oa(o), 1'b1, d, nm, 1'b0, 32'd0, 1'b0, 42'd0);
    endtask

    initial begin
        int         hold;
        int unsigned r;
        logic [3:0] o;
        logic [3:0] ofs_list [5];
        ofs_list = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8};
        hold = 0;

        // Reset state.
        rst_req = 1'b0;
        step(oa(4'd0), 1'b0, 32'd0, "rst_sw", 1'b1, 32'd0, 1'b1, HEX_ZEROS);
        rdc(4'd5, "rst_ctrl", 32'd1);
        rst_req = 1'b1;
        rdc(4'd4, "rst_hexd", 32'd0);
        rdc(4'd1, "rst_edge", 32'd0);
        rd(4'd8, "timer_run");

        // Clean change 00 -> A5: SW moves on the sixth edge after the change.
        cur_sw = 8'hA5;
        for (int i = 0; i < 6; i++) rdc(4'd0, "deb_wait", 32'd0);
        rdc(4'd0, "deb_done", 32'hA5);
        rdc(4'd1, "edge_a5", 32'hA5);

        // W1C, then a new edge on bit 0 coinciding with its clear.
        wr(4'd1, 32'h05, "w1c_wr");
        rdc(4'd1, "w1c_rd", 32'hA0);
        cur_sw = 8'hA4;
        for (int i = 0; i < 5; i++) rd(4'd0, "race_wait");
        wr(4'd1, 32'h01, "race_wr");
        rdc(4'd1, "race_edge", 32'hA1);
        rdc(4'd0, "race_sw", 32'hA4);

        // Three-cycle glitch must not be accepted.
        cur_sw = 8'h00;
        for (int i = 0; i < 8; i++) rd(4'd0, "settle");
        wr(4'd1, 32'hFF, "clr_all");
        rdc(4'd1, "clr_rd", 32'd0);
        cur_sw = 8'h01;
        for (int i = 0; i < 3; i++) rd(4'd0, "glitch");
        cur_sw = 8'h00;
        for (int i = 0; i < 5; i++) begin
            rdc(4'd0, "glitch_sw", 32'd0);
            rdc(4'd1, "glitch_edge", 32'd0);
        end

        // Hex display and blanking.
        wr(4'd4, 32'h0012_AB3F, "hexd_wr");
        wr(4'd5, 32'h01, "hexc_wr");
        step(oa(4'd4), 1'b0, 32'd0, "hex_show", 1'b1, 32'h0012_AB3F, 1'b1, HEX_12AB3F);
        wr(4'd5, 32'h05, "blank_wr");
        step(oa(4'd5), 1'b0, 32'd0, "hex_blank", 1'b1, 32'h05, 1'b1, HEX_BLANK1);

        // Timer load and wrap.
        wr(4'd8, 32'hFFFF_FFFE, "tmr_wr");
        rdc(4'd8, "tmr_load", 32'hFFFF_FFFE);
        rdc(4'd8, "tmr_max", 32'hFFFF_FFFF);
        rdc(4'd8, "tmr_wrap", 32'h0000_0000);

        // Writes outside the window change nothing.
        step(BASE + 32'h40, 1'b1, 32'hDEAD_BEEF, "oow_40", 1'b1, 32'd0, 1'b0, 42'd0);
        step(BASE + 32'h50, 1'b1, 32'h00FF_FFFF, "oow_50", 1'b1, 32'd0, 1'b0, 42'd0);
        rdc(4'd4, "oow_hexd", 32'h0012_AB3F);

        // Reset during debounce and while the display is active.
        cur_sw = 8'h3C;
        rd(4'd0, "pre_rst");
        rd(4'd0, "pre_rst");
        rst_req = 1'b0;
        step(oa(4'd5), 1'b0, 32'd0, "mid_rst_ctrl", 1'b1, 32'd1, 1'b1, HEX_ZEROS);
        rdc(4'd8, "mid_rst_tmr", 32'd0);
        rdc(4'd4, "mid_rst_hexd", 32'd0);
        rdc(4'd0, "mid_rst_sw", 32'd0);
        rst_req = 1'b1;
        for (int i = 0; i < 6; i++) rdc(4'd0, "post_rst_wait", 32'd0);
        rdc(4'd0, "post_rst_sw", 32'h3C);
        rdc(4'd1, "post_rst_edge", 32'h3C);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                cur_sw = ($urandom_range(0, 1) == 1) ? (cur_sw ^ (8'd1 << $urandom_range(0, 7)))
                                                     : 8'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            rst_req = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            r = $urandom_range(0, 99);
            o = ($urandom_range(0, 9) < 7) ? ofs_list[$urandom_range(0, 4)]
                                           : 4'($urandom_range(0, 15));
            if (r < 45) rd(o, "rnd_rd");
            else if (r < 90) wr(o, $urandom, "rnd_wr");
            else step($urandom, 1'($urandom), $urandom, "rnd_any", 1'b0, 32'd0, 1'b0, 42'd0);
        end

        @(posedge clock);
        @(negedge clock);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
